// File: rtl/wb_master_seq.sv
// wb_master_seq: single-outstanding Wishbone classic initiator.
// A command taken on the valid/ready port becomes one CYC/STB bus cycle.
// The cycle ends on ACK or on timeout, and its result is returned on the
// valid/ready response port. All bus and response outputs come from flops.
module wb_master_seq #(
  parameter int TIMEOUT = 16,
  parameter int ERR_W   = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic [31:0]      cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             busy_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  // The wait counter keeps at least one bit so that TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              ready_q, ready_n;
  logic              cyc, cyc_n;
  logic              we, we_n;
  logic [3:0]        sel, sel_n;
  logic [31:0]       adr, adr_n;
  logic [31:0]       wdat, wdat_n;
  logic              rvld, rvld_n;
  logic [31:0]       rdat, rdat_n;
  logic              rerr, rerr_n;
  logic [ERR_W-1:0]  ecnt, ecnt_n;

  // State and registered outputs. Reset clears everything, so a pending
  // command or response is dropped.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      cyc     <= 1'b0;
      we      <= 1'b0;
      sel     <= '0;
      adr     <= '0;
      wdat    <= '0;
      rvld    <= 1'b0;
      rdat    <= '0;
      rerr    <= 1'b0;
      ecnt    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_q <= ready_n;
      cyc     <= cyc_n;
      we      <= we_n;
      sel     <= sel_n;
      adr     <= adr_n;
      wdat    <= wdat_n;
      rvld    <= rvld_n;
      rdat    <= rdat_n;
      rerr    <= rerr_n;
      ecnt    <= ecnt_n;
    end
  end

  // Next-state logic. ACK is checked before the timeout, so an ACK on the
  // last allowed cycle completes normally. ACK outside BUS is ignored.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cyc_n   = cyc;
    we_n    = we;
    sel_n   = sel;
    adr_n   = adr;
    wdat_n  = wdat;
    rvld_n  = rvld;
    rdat_n  = rdat;
    rerr_n  = rerr;
    ecnt_n  = ecnt;
    unique case (state)
      IDLE: begin
        if (cmd_valid_i && ready_q) begin
          adr_n   = cmd_adr_i;
          wdat_n  = cmd_dat_i;
          sel_n   = cmd_sel_i;
          we_n    = cmd_we_i;
          cyc_n   = 1'b1;
          cnt_n   = '0;
          state_n = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          cyc_n   = 1'b0;
          rvld_n  = 1'b1;
          rdat_n  = we ? 32'h0 : wbm_dat_i;
          rerr_n  = 1'b0;
          state_n = RESP;
        end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
          cyc_n   = 1'b0;
          rvld_n  = 1'b1;
          rdat_n  = 32'h0;
          rerr_n  = 1'b1;
          if (ecnt != {ERR_W{1'b1}}) ecnt_n = ecnt + ERR_W'(1);
          state_n = RESP;
        end else if (TIMEOUT > 0) begin
          cnt_n = cnt + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rvld_n  = 1'b0;
          rdat_n  = 32'h0;
          rerr_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Ready is registered so that it stays low for the whole reset cycle.
    ready_n = (state_n == IDLE);
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rvld;
  assign rsp_dat_o   = rdat;
  assign rsp_err_o   = rerr;
  assign wbm_cyc_o   = cyc;
  assign wbm_stb_o   = cyc;
  assign wbm_we_o    = we;
  assign wbm_sel_o   = sel;
  assign wbm_adr_o   = adr;
  assign wbm_dat_o   = wdat;
  assign busy_o      = (state != IDLE);
  assign err_cnt_o   = ecnt;

endmodule

// File: tb/tb_wb_master_seq.sv
// tb_wb_master_seq: a table of bus transactions with a scoreboard of
// expected responses, plus hand-written reset and stray-ACK sequences.
module tb_wb_master_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, wwe;
  logic [3:0]  wsel;
  logic [31:0] wadr, wdat;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  wb_master_seq #(.TIMEOUT(16), .ERR_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(wwe),
    .wbm_sel_o(wsel), .wbm_adr_o(wadr), .wbm_dat_o(wdat), .wbm_ack_i(ack),
    .wbm_dat_i(rdata), .busy_o(busy), .err_cnt_o(err_cnt)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;   // BUS cycle (1-based) in which ACK is driven; 0 = never
    logic [31:0] rd;
    int          exp_cyc;  // expected number of cycles with CYC high
    logic        exp_err;
    logic [31:0] exp_dat;
    int          hold;     // cycles rsp_ready is held low
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  vec_t vecs[6];
  rsp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_ecnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int   n;
    int   waitc;
    logic bad;
    rsp_t e;
    logic [31:0] d0;
    logic        e0;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    @(posedge clk);
    sb.push_back('{err: v.exp_err, dat: v.exp_dat});
    if (v.exp_err) exp_ecnt++;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_in_bus", 64'(busy), 64'd1);
    n = 0;
    bad = 1'b0;
    while (cyc && n < 40) begin
      if (stb !== 1'b1 || wwe !== v.we || wadr !== v.adr || wsel !== v.sel ||
          (v.we && wdat !== v.dat) || cmd_ready !== 1'b0) bad = 1'b1;
      n++;
      ack   = (v.ack_at == n);
      rdata = v.rd;
      @(negedge clk);
    end
    ack = 1'b0;
    check("bus_hold_stable", 64'(bad), 64'd0);
    check("cyc_cycles", 64'(n), 64'(v.exp_cyc));
    check("stb_low_after", 64'(stb), 64'd0);
    check("rsp_valid_after_bus", 64'(rsp_valid), 64'd1);
    d0 = rsp_dat; e0 = rsp_err;
    bad = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dat !== d0 || rsp_err !== e0 || cmd_ready !== 1'b0)
        bad = 1'b1;
    end
    check("rsp_hold_stable", 64'(bad), 64'd0);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check("rsp_dat", 64'(rsp_dat), 64'(e.dat));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
    check("err_cnt", 64'(err_cnt), 64'(exp_ecnt));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
    check("cmd_ready_after", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF, 3,  32'hFFFF_FFFF, 3,  1'b0, 32'h0,         0};
    vecs[1] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1,  32'hCAFE_F00D, 1,  1'b0, 32'hCAFE_F00D, 0};
    vecs[2] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 0,  32'h1111_1111, 16, 1'b1, 32'h0,         0};
    vecs[3] = '{1'b0, 32'h3000_000C, 32'h0,         4'h1, 16, 32'h1234_5678, 16, 1'b0, 32'h1234_5678, 0};
    vecs[4] = '{1'b1, 32'h3000_0010, 32'h0000_00FF, 4'h3, 2,  32'hDEAD_BEEF, 2,  1'b0, 32'h0,         0};
    vecs[5] = '{1'b0, 32'h3000_0014, 32'h0,         4'hC, 2,  32'h0BAD_F00D, 2,  1'b0, 32'h0BAD_F00D, 5};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0; ack = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_cyc", 64'(cyc), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(cmd_ready), 64'd1);

    for (int k = 0; k < 6; k++) run_txn(vecs[k]);

    // Stray ACK while idle must not start anything.
    ack = 1'b1; rdata = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    check("stray_busy", 64'(busy), 64'd0);
    check("stray_cyc", 64'(cyc), 64'd0);
    check("stray_rsp_valid", 64'(rsp_valid), 64'd0);
    check("stray_err_cnt", 64'(err_cnt), 64'(exp_ecnt));

    // Reset in the middle of a bus cycle drops the command.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    @(posedge clk);
    sb.push_back('{err: 1'b0, dat: 32'h0});
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_cyc_before_rst", 64'(cyc), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    exp_ecnt = 0;
    @(negedge clk);
    check("mid_rst_cyc", 64'(cyc), 64'd0);
    check("mid_rst_stb", 64'(stb), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Normal traffic resumes after the reset.
    run_txn(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
